// File: rtl/wfunc_regs_pkg.sv
// Register map shared by the window block and its APB loader.
// Offsets depend on FFT_SIZE, so they are exposed as helper functions.
package wfunc_regs_pkg;

  localparam int CTRL_SOFT_RST_BIT     = 0;
  localparam int CTRL_CHANGE_STATE_BIT = 8;
  localparam int STATUS_STATE_LSB      = 8;

  localparam logic [31:0] CTRL_SOFT_RST     = 32'h1 << CTRL_SOFT_RST_BIT;
  localparam logic [31:0] CTRL_CHANGE_STATE = 32'h1 << CTRL_CHANGE_STATE_BIT;

  typedef enum logic [1:0] {
    WIN_IDLE = 2'd0,
    WIN_WAIT = 2'd1,
    WIN_BUSY = 2'd2
  } win_state_e;

  typedef enum logic [1:0] {
    ERR_OK           = 2'd0,
    ERR_EARLY_TLAST  = 2'd1,
    ERR_NO_TLAST     = 2'd2,
    ERR_POLL_TIMEOUT = 2'd3
  } load_err_e;

  function automatic logic [31:0] ctrl_offset(input int unsigned fft_size);
    return 32'(fft_size * 4);
  endfunction

  function automatic logic [31:0] status_offset(input int unsigned fft_size);
    return 32'((fft_size + 1) * 4);
  endfunction

endpackage

// File: rtl/wfunc_apb_loader_if.sv
// APB bus between the window loader (master) and the window block (slave).
// Two-phase slave: no pready, every transfer is exactly setup + access.
interface wfunc_apb_loader_if #(parameter int AW = 16);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_master_xfer.sv
// Setup/access sequencer for a pready-less APB slave; req accepted when rdy.
// Latency: setup the cycle after req, ack on the access cycle; back-to-back allowed.
module apb_master_xfer #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ack,
  output logic          rdy,
  output logic [31:0]   rdata,
  wfunc_apb_loader_if.master apb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
    end else if (req && rdy) begin
      apb.psel    <= 1'b1;
      apb.penable <= 1'b0;
      apb.pwrite  <= wr;
      apb.paddr   <= addr;
      // pwdata keeps its last written value across reads
      if (wr) apb.pwdata <= wdata;
    end else if (apb.psel && !apb.penable) begin
      apb.penable <= 1'b1;
    end else begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
    end
  end

  assign ack   = apb.psel && apb.penable;
  assign rdy   = !apb.psel || apb.penable;
  assign rdata = apb.prdata;

endmodule

// File: rtl/wfunc_apb_loader.sv
// Streams FFT_SIZE coefficient words into the window block over APB, then arms and polls it.
// Peak 1 word / 2 cycles; in_tready only while the APB sequencer can take a new transfer.
module wfunc_apb_loader
  import wfunc_regs_pkg::*;
#(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+2+1,
  parameter int POLL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  input  logic [31:0] in_tdata,
  wfunc_apb_loader_if.master apb
);

  localparam int IDXW = $clog2(FFT_SIZE);
  localparam int PCW  = $clog2(POLL_MAX+1);
  localparam logic [IDXW-1:0]   IDX_LAST    = IDXW'(FFT_SIZE-1);
  localparam logic [PCW-1:0]    POLL_LIM    = PCW'(POLL_MAX);
  localparam logic [APB_AW-1:0] CTRL_ADDR   = APB_AW'(ctrl_offset(FFT_SIZE));
  localparam logic [APB_AW-1:0] STATUS_ADDR = APB_AW'(status_offset(FFT_SIZE));

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_DRAIN, S_ARM, S_POLL, S_ABORT, S_FIN
  } ld_state_e;

  ld_state_e       state;
  logic [IDXW-1:0] idx;
  logic [PCW-1:0]  pcnt;
  logic            pend;
  load_err_e       err_q;

  logic              req, req_wr, xfer_ack, xfer_rdy;
  logic [APB_AW-1:0] req_addr;
  logic [31:0]       req_wdata, xfer_rdata;
  logic              status_hit;
  logic              unused_rdata;

  assign status_hit   = xfer_rdata[STATUS_STATE_LSB +: 2] == WIN_WAIT;
  assign unused_rdata = ^{xfer_rdata[31:STATUS_STATE_LSB+2], xfer_rdata[STATUS_STATE_LSB-1:0]};
  assign err          = err_q;

  // pend marks a transfer issued by the current state whose ack is still awaited
  always_comb begin
    req       = 1'b0;
    req_wr    = 1'b1;
    req_addr  = CTRL_ADDR;
    req_wdata = CTRL_SOFT_RST;
    in_tready = 1'b0;
    unique case (state)
      S_IDLE: req = start;
      S_LOAD: begin
        in_tready = xfer_rdy;
        if (in_tvalid && xfer_rdy) begin
          req       = 1'b1;
          req_addr  = APB_AW'({idx, 2'b00});
          req_wdata = in_tdata;
        end
      end
      S_DRAIN: in_tready = 1'b1;
      S_ARM: begin
        req       = xfer_rdy;
        req_wdata = CTRL_CHANGE_STATE;
      end
      S_POLL: begin
        req_wr   = 1'b0;
        req_addr = STATUS_ADDR;
        req      = xfer_rdy && (!pend || (xfer_ack && !status_hit && pcnt != POLL_LIM));
      end
      S_ABORT: req = xfer_rdy && !pend;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      pcnt  <= '0;
      pend  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err_q <= ERR_OK;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          state <= S_RST;
          busy  <= 1'b1;
          idx   <= '0;
          err_q <= ERR_OK;
        end
        S_RST: state <= S_LOAD;
        S_LOAD: if (in_tvalid && in_tready) begin
          if (idx == IDX_LAST) begin
            if (in_tlast) state <= S_ARM;
            else begin
              state <= S_DRAIN;
              err_q <= ERR_NO_TLAST;
            end
          end else begin
            idx <= idx + 1'b1;
            if (in_tlast) begin
              state <= S_ABORT;
              err_q <= ERR_EARLY_TLAST;
            end
          end
        end
        S_DRAIN: if (in_tvalid && in_tlast) state <= S_ABORT;
        S_ARM: if (xfer_rdy) begin
          state <= S_POLL;
          pend  <= 1'b0;
          pcnt  <= '0;
        end
        S_POLL: begin
          if (pend && xfer_ack && status_hit) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            pend  <= 1'b0;
          end else if (pend && xfer_ack && pcnt == POLL_LIM) begin
            state <= S_ABORT;
            err_q <= ERR_POLL_TIMEOUT;
            pend  <= 1'b0;
          end
          if (req) begin
            pend <= 1'b1;
            pcnt <= pcnt + 1'b1;
          end
        end
        S_ABORT: begin
          if (req) pend <= 1'b1;
          else if (pend && xfer_ack) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            pend  <= 1'b0;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  apb_master_xfer #(.AW(APB_AW)) u_xfer (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wr    (req_wr),
    .addr  (req_addr),
    .wdata (req_wdata),
    .ack   (xfer_ack),
    .rdy   (xfer_rdy),
    .rdata (xfer_rdata),
    .apb   (apb)
  );

endmodule

// File: tb/tb_wfunc_apb_loader.sv
// Bench for wfunc_apb_loader at FFT_SIZE=16: random streams and status replies
// are checked against an expected APB transaction list derived from the load rules.
module tb_wfunc_apb_loader;
  localparam int N  = 16;
  localparam int AW = $clog2(N-1)+2+1;
  localparam int PM = 8;
  localparam logic [31:0] CTRL = 32'(N*4);
  localparam logic [31:0] STAT = 32'((N+1)*4);

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, done, in_tready;
  logic [1:0]  err;
  logic        in_tvalid = 1'b0, in_tlast = 1'b0;
  logic [31:0] in_tdata = '0;

  wfunc_apb_loader_if #(.AW(AW)) apb();

  wfunc_apb_loader #(.FFT_SIZE(N), .APB_AW(AW), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .apb(apb)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // APB slave model + monitor
  bit          mw[$];
  logic [31:0] ma[$], md[$];
  int          psel_cyc = 0, proto_bad = 0, rd_seen = 0, hit_on = 0;
  logic        pp = 0, pe = 0, pwr = 0;
  logic [31:0] pa = '0, pd = '0, rd_val;

  always @(negedge clk) begin
    if (rst) begin
      pp = 0; pe = 0; apb.prdata = '0;
    end else begin
      if (apb.psel) psel_cyc++;
      if (apb.penable && !apb.psel) proto_bad++;
      if (apb.psel && apb.penable) begin
        if (!(pp && !pe) || pwr !== apb.pwrite || pa !== 32'(apb.paddr) ||
            (apb.pwrite && pd !== apb.pwdata)) proto_bad++;
        mw.push_back(apb.pwrite);
        ma.push_back(32'(apb.paddr));
        md.push_back(apb.pwrite ? apb.pwdata : 32'h0);
        if (!apb.pwrite) rd_seen++;
      end
      if (apb.psel && !apb.penable) begin
        if (pp && !pe) proto_bad++;
        if (!apb.pwrite) begin
          rd_val = $urandom;
          rd_val[9:8] = (hit_on != 0 && rd_seen + 1 == hit_on) ? 2'b01 : 2'($urandom_range(0, 1) * 2);
          apb.prdata = rd_val;
        end
      end
      pp = apb.psel; pe = apb.penable; pwr = apb.pwrite;
      pa = 32'(apb.paddr); pd = apb.pwdata;
    end
  end

  // Stream source
  logic [31:0] words[$];
  bit          lasts[$];
  bit          drv_stop = 0;
  int          drv_taken = 0, first_hs = -1, t0 = 0;

  task automatic drive(input int mode);
    int i = 0;
    int c = 0;
    while (i < words.size() && !drv_stop) begin
      @(negedge clk);
      case (mode)
        0:       in_tvalid = 1'b1;
        1:       in_tvalid = ((c / 3) % 2) == 0;
        default: in_tvalid = $urandom_range(0, 3) != 0;
      endcase
      c++;
      in_tdata = words[i];
      in_tlast = lasts[i];
      if (in_tvalid && in_tready) begin
        if (first_hs < 0) first_hs = cyc;
        i++;
      end
    end
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    drv_taken = i;
  endtask

  task automatic rst_state_chk(input string nm);
    chk({nm, "_psel"},    32'(apb.psel), 0);
    chk({nm, "_penable"}, 32'(apb.penable), 0);
    chk({nm, "_pwrite"},  32'(apb.pwrite), 0);
    chk({nm, "_paddr"},   32'(apb.paddr), 0);
    chk({nm, "_pwdata"},  apb.pwdata, 0);
    chk({nm, "_tready"},  32'(in_tready), 0);
    chk({nm, "_busy"},    32'(busy), 0);
    chk({nm, "_done"},    32'(done), 0);
    chk({nm, "_err"},     32'(err), 0);
  endtask

  task automatic prep(input int last_idx, input bit fixed, input int hit);
    words.delete(); lasts.delete();
    for (int j = 0; j <= last_idx; j++) begin
      words.push_back(fixed ? 32'h0001_0000 + 32'(j) : $urandom);
      lasts.push_back(j == last_idx);
    end
    mw.delete(); ma.delete(); md.delete();
    psel_cyc = 0; proto_bad = 0; rd_seen = 0; hit_on = hit; first_hs = -1;
  endtask

  task automatic run_load(input string nm, input int last_idx, input int mode, input int hit,
                          input bit fixed, input bit timing, input bit extra);
    bit          ew[$];
    logic [31:0] ea[$], ed[$];
    int          e_err, k, nrd, dt;
    bit          got;
    prep(last_idx, fixed, hit);
    // expected transaction list from the load rules
    ew.push_back(1); ea.push_back(CTRL); ed.push_back(32'h1);
    k = (last_idx < N-1) ? last_idx : N-1;
    for (int j = 0; j <= k; j++) begin
      ew.push_back(1); ea.push_back(32'(j*4)); ed.push_back(words[j]);
    end
    if (last_idx == N-1) begin
      ew.push_back(1); ea.push_back(CTRL); ed.push_back(32'h100);
      nrd = (hit == 0 || hit > PM) ? PM : hit;
      for (int r = 0; r < nrd; r++) begin
        ew.push_back(0); ea.push_back(STAT); ed.push_back(32'h0);
      end
      if (hit == 0 || hit > PM) begin
        ew.push_back(1); ea.push_back(CTRL); ed.push_back(32'h1);
        e_err = 3;
      end else e_err = 0;
    end else begin
      ew.push_back(1); ea.push_back(CTRL); ed.push_back(32'h1);
      e_err = (last_idx < N-1) ? 1 : 2;
    end

    fork
      drive(mode);
      begin
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        chk({nm, "_busy_on"}, 32'(busy), 1);
        got = 0;
        while (!got && cyc - t0 < 3000) begin
          @(negedge clk);
          if (done) got = 1;
          else start = extra && (cyc - t0 == 10);
        end
        chk({nm, "_done_seen"}, 32'(got), 1);
        dt = cyc - t0;
        chk({nm, "_err"}, 32'(err), 32'(e_err));
        if (timing) chk({nm, "_latency"}, 32'(dt), 32'(2*N+7));
        start = timing;
        @(negedge clk); start = 1'b0;
        chk({nm, "_done_pulse"}, 32'(done), 0);
        chk({nm, "_busy_off"},   32'(busy), 0);
        chk({nm, "_err_hold"},   32'(err), 32'(e_err));
        drv_stop = 1;
      end
    join
    drv_stop = 0;

    chk({nm, "_consumed"}, 32'(drv_taken), 32'(last_idx + 1));
    chk({nm, "_n_txn"}, 32'(mw.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < mw.size(); i++) begin
      chk($sformatf("%s_txn%0d_addr", nm, i), {ma[i][30:0], mw[i]}, {ea[i][30:0], ew[i]});
      if (ew[i]) chk($sformatf("%s_txn%0d_data", nm, i), md[i], ed[i]);
    end
    chk({nm, "_psel_cycles"}, 32'(psel_cyc), 32'(2 * ew.size()));
    chk({nm, "_proto"}, 32'(proto_bad), 0);
    if (timing) chk({nm, "_first_ready"}, 32'(first_hs - t0), 2);
  endtask

  task automatic reset_mid_load();
    bit found;
    int waited;
    prep(N-1, 1'b1, 1);
    fork
      drive(0);
      begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0; waited = 0;
        while (!found && waited < 200) begin
          @(negedge clk); waited++;
          if (apb.psel && apb.penable && apb.pwrite &&
              32'(apb.paddr) >= 8 && 32'(apb.paddr) < CTRL) found = 1;
        end
        chk("rstmid_found", 32'(found), 1);
        rst = 1'b1; drv_stop = 1;
        @(negedge clk);
        rst_state_chk("rstmid");
        rst = 1'b0;
      end
    join
    drv_stop = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst_state_chk("reset");
    rst = 1'b0;
    @(negedge clk);

    run_load("clean",    N-1, 0, 1, 1'b1, 1'b1, 1'b0);
    run_load("bp",       N-1, 1, 3, 1'b0, 1'b0, 1'b1);
    run_load("early",    5,   2, 1, 1'b0, 1'b0, 1'b0);
    run_load("notlast",  19,  2, 1, 1'b0, 1'b0, 1'b0);
    run_load("timeout",  N-1, 0, 0, 1'b0, 1'b0, 1'b0);
    reset_mid_load();
    run_load("after_rst", N-1, 0, 1, 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++)
      run_load($sformatf("rnd%0d", r), $urandom_range(0, 21), 2,
               $urandom_range(0, 10), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
